// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the ALU: issues one operand set at a time, samples the
// result ALU_LAT cycles later and queues it in a response FIFO. Optional tag path: ALU_SEQ_TAG_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_o,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_bo,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c,
    output logic             rsp_bo,
`ifdef ALU_SEQ_TAG_EN
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       rsp_tag,
`endif
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef ALU_SEQ_TAG_EN
    localparam int TAGW = 4;
`else
    localparam int TAGW = 0;
`endif
    localparam int EW = WIDTH + 2 + TAGW;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [OPW-1:0]    o_q, o_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [EW-1:0]     entry_in, head;
    logic              accept, push, pop;
`ifdef ALU_SEQ_TAG_EN
    logic [3:0]        tag_q, tag_d;
`endif

    always_comb begin
        cmd_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && rst;
        accept    = cmd_valid && cmd_ready;
        // The capture edge is the one on which the countdown has reached zero.
        push      = (state_q == S_WAIT) && (cnt_q == 4'd0);
        rsp_valid = (count_q != '0);
        pop       = rsp_valid && rsp_ready;
`ifdef ALU_SEQ_TAG_EN
        entry_in  = {alu_result, alu_c, alu_bo, tag_q};
`else
        entry_in  = {alu_result, alu_c, alu_bo};
`endif

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
`ifdef ALU_SEQ_TAG_EN
        tag_d   = tag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    o_d     = cmd_op;
                    cnt_d   = 4'(ALU_LAT - 1);
                    state_d = S_WAIT;
`ifdef ALU_SEQ_TAG_EN
                    tag_d   = cmd_tag;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = entry_in;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            o_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef ALU_SEQ_TAG_EN
            tag_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            o_q      <= o_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef ALU_SEQ_TAG_EN
            tag_q    <= tag_d;
`endif
        end
    end

    // Storage is not reset: entries are only visible while count_q says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        rsp_result = rsp_valid ? head[EW-1 -: WIDTH] : '0;
        rsp_c      = rsp_valid ? head[TAGW+1] : 1'b0;
        rsp_bo     = rsp_valid ? head[TAGW] : 1'b0;
`ifdef ALU_SEQ_TAG_EN
        rsp_tag    = rsp_valid ? head[3:0] : 4'd0;
`endif
        alu_a      = a_q;
        alu_b      = b_q;
        alu_o      = o_q;
        busy       = (state_q == S_WAIT);
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [OPW-1:0]   cmd_op, alu_o;
    logic             alu_c, alu_bo, rsp_c, rsp_bo, busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference ALU: op 0 add (carry), 1 sub (borrow), 2 and, 3 or, others xor.
    function automatic logic [9:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        int s;
        logic [7:0] r;
        logic c, bo;
        c = 1'b0;
        bo = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
            3'd1: begin r = a - b; bo = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = a ^ b;
        endcase
        return {r, c, bo};
    endfunction

    logic [9:0] alu_out;
    assign alu_out    = ref_alu(alu_a, alu_b, alu_o);
    assign alu_result = alu_out[9:2];
    assign alu_c      = alu_out[1];
    assign alu_bo     = alu_out[0];

    alu_cmd_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
        .alu_result(alu_result), .alu_c(alu_c), .alu_bo(alu_bo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_c(rsp_c), .rsp_bo(rsp_bo), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int w;
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic [2:0] op;
        logic [7:0] r;
        logic       c, bo;
    } vec_t;

    vec_t tbl[8];
    logic [7:0] drain_exp[3];
    logic [9:0] q[$];
    logic [9:0] pend;
    logic [7:0] acc_a;
    logic       infl, exp_ready;
    int         cap_t, t;

    initial begin
        tbl[0] = '{8'h0F, 8'h01, 3'd0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'h55, 8'h0F, 3'd2, 8'h05, 1'b0, 1'b0};
        tbl[5] = '{8'h50, 8'h0F, 3'd3, 8'h5F, 1'b0, 1'b0};
        tbl[6] = '{8'h3C, 8'hFF, 3'd4, 8'hC3, 1'b0, 1'b0};
        tbl[7] = '{8'h10, 8'h10, 3'd1, 8'h00, 1'b0, 1'b0};
        drain_exp[0] = 8'h46;
        drain_exp[1] = 8'h07;
        drain_exp[2] = 8'h11;

        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_o}), 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Single op with latency tracking
        cmd_valid = 1'b1;
        cmd_a = 8'h0F;
        cmd_b = 8'h01;
        cmd_op = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("single_alu_a", 32'(alu_a), 32'h0F);
        chk("single_busy0", 32'(busy), 32'd1);
        chk("single_ready0", 32'(cmd_ready), 32'd0);
        chk("single_valid0", 32'(rsp_valid), 32'd0);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            chk("lat_busy", 32'(busy), 32'd1);
            chk("lat_ready", 32'(cmd_ready), 32'd0);
            chk("lat_valid", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("cap_busy", 32'(busy), 32'd0);
        chk("cap_ready", 32'(cmd_ready), 32'd1);
        chk("cap_valid", 32'(rsp_valid), 32'd1);
        chk("cap_result", 32'(rsp_result), 32'h10);
        chk("cap_flags", 32'({rsp_c, rsp_bo}), 32'd0);
        pop_one();
        chk("pop_valid", 32'(rsp_valid), 32'd0);
        chk("pop_result_zero", 32'(rsp_result), 32'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].op);
            wait_rsp();
            chk("tbl_result", 32'(rsp_result), 32'(tbl[i].r));
            chk("tbl_c", 32'(rsp_c), 32'(tbl[i].c));
            chk("tbl_bo", 32'(rsp_bo), 32'(tbl[i].bo));
            pop_one();
        end

        // Full FIFO and backpressure
        send(8'hFF, 8'h01, 3'd0);
        send(8'h00, 8'h01, 3'd1);
        send(8'h12, 8'h34, 3'd0);
        send(8'h0A, 8'h03, 3'd1);
        cmd_valid = 1'b1;
        cmd_a = 8'h77;
        cmd_b = 8'h11;
        cmd_op = 3'd2;
        repeat (LAT + 2) @(negedge clk);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_head", 32'({rsp_result, rsp_c, rsp_bo}), 32'({8'h00, 1'b1, 1'b0}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_pop", 32'(cmd_ready), 32'd1);
        chk("head_after_pop", 32'({rsp_result, rsp_c, rsp_bo}), 32'({8'hFF, 1'b0, 1'b1}));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fifth_accepted", 32'(busy), 32'd1);
        chk("fifth_alu_a", 32'(alu_a), 32'h77);
        pop_one();
        repeat (LAT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("drain_valid", 32'(rsp_valid), 32'd1);
            chk("drain_result", 32'(rsp_result), 32'(drain_exp[i]));
            pop_one();
        end
        chk("drain_empty", 32'(rsp_valid), 32'd0);

        // Push and pop on the same edge
        send(8'h21, 8'h01, 3'd0);
        wait_rsp();
        send(8'h30, 8'h01, 3'd1);
        repeat (LAT - 1) @(negedge clk);
        chk("pp_head_before", 32'(rsp_result), 32'h22);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("pp_valid", 32'(rsp_valid), 32'd1);
        chk("pp_head_after", 32'(rsp_result), 32'h2F);
        pop_one();
        chk("pp_empty", 32'(rsp_valid), 32'd0);

        // Reset while a command is in flight
        send(8'h01, 8'h02, 3'd0);
        wait_rsp();
        send(8'h05, 8'h06, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_alu", 32'({alu_a, alu_b, alu_o}), 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd0);
        chk("mrst_result", 32'(rsp_result), 32'd0);
        rst = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("mrst_no_stale", 32'(rsp_valid), 32'd0);
        chk("mrst_idle", 32'(busy), 32'd0);

        // Randomized run against the queue model
        infl = 1'b0;
        cap_t = 0;
        t = 0;
        pend = '0;
        acc_a = '0;
        for (int k = 0; k < 500; k++) begin
            exp_ready = !infl && (q.size() < DEPTH);
            chk("r_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("r_valid", 32'(rsp_valid), 32'(q.size() != 0));
            chk("r_busy", 32'(busy), 32'(infl));
            if (infl) chk("r_alu_a", 32'(alu_a), 32'(acc_a));
            if (q.size() != 0) chk("r_head", 32'({rsp_result, rsp_c, rsp_bo}), 32'(q[0]));
            else chk("r_empty_zero", 32'({rsp_result, rsp_c, rsp_bo}), 32'd0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_op = 3'($urandom_range(0, 4));
            rsp_ready = ($urandom_range(0, 2) == 0);
            if (q.size() != 0 && rsp_ready) void'(q.pop_front());
            if (infl && t == cap_t) begin
                q.push_back(pend);
                infl = 1'b0;
            end
            if (cmd_valid && exp_ready) begin
                pend = ref_alu(cmd_a, cmd_b, cmd_op);
                acc_a = cmd_a;
                infl = 1'b1;
                cap_t = t + LAT;
            end
            t++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
